// File: rtl/spi_packet_master.sv
// SPI master for 32-bit NoC command packets: MSB-first on mosi under cs_n framing,
// with the 32 miso bits of each frame handed back once the frame closes.
module spi_packet_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [31:0] tx_data,
    output logic        rx_valid,
    output logic [31:0] rx_data,
    output logic        busy,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [7:0]  gap_q, gap_d;
    logic [30:0] tx_sh_q, tx_sh_d;
    logic [31:0] rx_sh_q, rx_sh_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_ready_q, tx_ready_d;
    logic        busy_q, busy_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    state_d    = S_SETUP;
                    tx_sh_d    = tx_data[30:0];
                    mosi_d     = tx_data[31];
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    div_d      = DIV_LOAD;
                    bit_d      = '0;
                end
            end
            S_SETUP: begin
                if (div_q == 8'd0) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[30:0], miso};
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            S_SHIFT: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (sclk_q) begin
                    sclk_d = 1'b0;
                    div_d  = DIV_LOAD;
                    bit_d  = bit_q + 6'd1;
                    // after the last bit mosi holds packet[0] through the hold half
                    if (bit_q != 6'd31) begin
                        mosi_d  = tx_sh_q[30];
                        tx_sh_d = {tx_sh_q[29:0], 1'b0};
                    end
                end else if (bit_q == 6'd32) begin
                    state_d    = S_DONE;
                    cs_n_d     = 1'b1;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end else begin
                    sclk_d  = 1'b1;
                    div_d   = DIV_LOAD;
                    rx_sh_d = {rx_sh_q[30:0], miso};
                end
            end
            S_DONE: begin
                if (GAP == 0) begin
                    state_d    = S_IDLE;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    state_d = S_WAIT;
                    gap_d   = GAP_LOAD;
                end
            end
            S_WAIT: begin
                if (gap_q == 8'd0) begin
                    state_d    = S_IDLE;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_packet_master.sv
// Directed bench for spi_packet_master (CLK_DIV=4, GAP=2): framing, data, gap,
// mid-frame reset and input isolation while busy.
module tb_spi_packet_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        busy;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [1:0]  miso_mode;

    int n_cmp = 0;
    int n_err = 0;

    // 0: miso low, 1: miso high, 2: loopback from mosi
    assign miso = (miso_mode == 2'd2) ? mosi : (miso_mode == 2'd1);

    spi_packet_master #(.CLK_DIV(4), .GAP(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int g;
        g = 0;
        while (tx_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        ok = (tx_ready === 1'b1);
    endtask

    // Follows one frame from the first cs_n-low sample to the first cs_n-high sample.
    task automatic watch_frame(input bit toggle,
                               output logic [31:0] bits, output int low, output int rises,
                               output bit rxv_end, output int rxv_early, output int mosi_bad,
                               output logic first_mosi, output int rdy_seen);
        int g;
        logic prev_sclk, prev_mosi;
        bits = '0; low = 0; rises = 0; rxv_end = 0; rxv_early = 0;
        mosi_bad = 0; first_mosi = 1'bx; rdy_seen = 0;
        prev_sclk = 1'b0; prev_mosi = 1'b0;
        g = 0;
        while (cs_n !== 1'b0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        g = 0;
        while (cs_n === 1'b0 && g < 3000) begin
            if (low == 0) first_mosi = mosi;
            else if (sclk && mosi !== prev_mosi) mosi_bad++;
            low++;
            if (sclk && !prev_sclk) begin
                rises++;
                bits = {bits[30:0], mosi};
            end
            if (rx_valid) rxv_early++;
            if (tx_ready) rdy_seen++;
            if (toggle) begin
                tx_valid = ~tx_valid;
                tx_data  = 32'hFFFF_FFFF;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            @(negedge clk);
            g++;
        end
        rxv_end = rx_valid;
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (cs_n === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] bits;
        int low, rises, rxv_early, mosi_bad, rdy_seen, gap, r, g, rxv;
        bit rxv_end, ok;
        logic first_mosi, prev;

        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; miso_mode = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // reset held for 3 cycles while idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_rise", 32'(tx_ready), 32'd1);

        // single write frame, miso low
        tx_valid = 1'b1; tx_data = 32'h1004_0155;
        @(negedge clk);
        tx_valid = 1'b0;
        check("w_busy", 32'(busy), 32'd1);
        check("w_ready_low", 32'(tx_ready), 32'd0);
        watch_frame(1'b0, bits, low, rises, rxv_end, rxv_early, mosi_bad, first_mosi, rdy_seen);
        check("w_cs_low", low, 32'd260);
        check("w_rises", rises, 32'd32);
        check("w_bits", bits, 32'h1004_0155);
        check("w_rxv_end", 32'(rxv_end), 32'd1);
        check("w_rxv_early", rxv_early, 32'd0);
        check("w_mosi_stable", mosi_bad, 32'd0);
        check("w_rx_data", rx_data, 32'd0);
        @(negedge clk);
        check("w_rxv_pulse", 32'(rx_valid), 32'd0);
        check("w_busy_gap", 32'(busy), 32'd1);

        // loopback
        miso_mode = 2'd2;
        wait_ready(ok);
        check("lb_ready", 32'(ok), 32'd1);
        tx_valid = 1'b1; tx_data = 32'hA5C3_0F96;
        @(negedge clk);
        tx_valid = 1'b0;
        watch_frame(1'b0, bits, low, rises, rxv_end, rxv_early, mosi_bad, first_mosi, rdy_seen);
        check("lb_rxv", 32'(rxv_end), 32'd1);
        check("lb_rx_data", rx_data, 32'hA5C3_0F96);
        check("lb_bits", bits, 32'hA5C3_0F96);

        // back-to-back with tx_valid held, miso high
        miso_mode = 2'd1;
        wait_ready(ok);
        check("b2b_ready", 32'(ok), 32'd1);
        tx_valid = 1'b1; tx_data = 32'h1004_0155;
        @(negedge clk);
        tx_data = 32'h2004_0000;
        watch_frame(1'b0, bits, low, rises, rxv_end, rxv_early, mosi_bad, first_mosi, rdy_seen);
        check("b2b1_bits", bits, 32'h1004_0155);
        check("b2b1_rx", rx_data, 32'hFFFF_FFFF);
        check("b2b1_rxv", 32'(rxv_end), 32'd1);
        count_high(gap);
        check("b2b_gap", gap, 32'd4);
        tx_valid = 1'b0;
        watch_frame(1'b0, bits, low, rises, rxv_end, rxv_early, mosi_bad, first_mosi, rdy_seen);
        check("b2b2_bits", bits, 32'h2004_0000);
        check("b2b2_rx", rx_data, 32'hFFFF_FFFF);
        check("b2b2_cs_low", low, 32'd260);

        // reset after the 10th sclk rising edge
        miso_mode = 2'd0;
        wait_ready(ok);
        tx_valid = 1'b1; tx_data = 32'h1234_5678;
        @(negedge clk);
        tx_valid = 1'b0;
        r = 0; g = 0; prev = 1'b0;
        while (r < 10 && g < 500) begin
            @(negedge clk);
            g++;
            if (sclk && !prev) r++;
            prev = sclk;
        end
        check("mr_rises", r, 32'd10);
        rst = 1'b1;
        @(negedge clk);
        check("mr_cs_n", 32'(cs_n), 32'd1);
        check("mr_sclk", 32'(sclk), 32'd0);
        check("mr_rx_valid", 32'(rx_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rx_data", rx_data, 32'd0);
        rst = 1'b0;
        rxv = 0;
        repeat (12) begin
            @(negedge clk);
            if (rx_valid) rxv++;
        end
        check("mr_no_rxv", rxv, 32'd0);
        wait_ready(ok);
        tx_valid = 1'b1; tx_data = 32'h8000_0001;
        @(negedge clk);
        tx_valid = 1'b0;
        watch_frame(1'b0, bits, low, rises, rxv_end, rxv_early, mosi_bad, first_mosi, rdy_seen);
        check("mr_first_mosi", 32'(first_mosi), 32'd1);
        check("mr_bits", bits, 32'h8000_0001);
        check("mr_cs_low", low, 32'd260);

        // input activity during a frame is ignored
        wait_ready(ok);
        tx_valid = 1'b1; tx_data = 32'h0F0F_00F0;
        @(negedge clk);
        tx_valid = 1'b0;
        watch_frame(1'b1, bits, low, rises, rxv_end, rxv_early, mosi_bad, first_mosi, rdy_seen);
        check("iso_ready_low", rdy_seen, 32'd0);
        check("iso_bits", bits, 32'h0F0F_00F0);
        tx_valid = 1'b1;
        tx_data  = 32'hFFFF_FFFF;
        count_high(gap);
        check("iso_gap", gap, 32'd4);
        tx_valid = 1'b0;
        watch_frame(1'b0, bits, low, rises, rxv_end, rxv_early, mosi_bad, first_mosi, rdy_seen);
        check("iso_next_bits", bits, 32'hFFFF_FFFF);
        check("iso_next_rises", rises, 32'd32);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
